// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: brings aud_bclk/aud_adclrck/aud_adcdat into clk50 and deserializes left/right words.
// Optional peak meter is built only when I2S_RX_PEAK_EN is defined.
module i2s_adc_rx #(
  parameter int DATA_W = 16
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  input  logic              peak_clr,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              framing_err,
  output logic [DATA_W-1:0] peak_level,
  output logic [1:0]        dbg_state
);
  // Handshake: sample_valid is a valid-only strobe with no ready; left_data/right_data
  // are updated in the same cycle the strobe is high and hold until the next strobe.

  typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, SHIFT = 2'd2, DRAIN = 2'd3} state_t;

  localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

  state_t              state;
  logic [2:0]          bclk_sync;
  logic [2:0]          lrck_sync;
  logic [1:0]          dat_sync;
  logic                bclk_rise;
  logic                lrck_edge;
  logic                lrck_lvl;
  logic                dat_bit;
  logic                chan;
  logic [4:0]          bit_cnt;
  logic [DATA_W-2:0]   shreg;
  logic [DATA_W-1:0]   word_next;
  logic [DATA_W-1:0]   left_hold;
  logic [DATA_W-1:0]   right_hold;
  logic                have_left;
  logic                pair_pend;

  // Data path is only two flops deep so it lines up with the bclk edge detector.
  always_ff @(posedge clk50) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], aud_bclk};
      lrck_sync <= {lrck_sync[1:0], aud_adclrck};
      dat_sync  <= {dat_sync[0], aud_adcdat};
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
  assign lrck_edge = lrck_sync[1] ^ lrck_sync[2];
  assign lrck_lvl  = lrck_sync[1];
  assign dat_bit   = dat_sync[1];
  assign word_next = {shreg, dat_bit};
  assign dbg_state = state;

  always_ff @(posedge clk50) begin
    if (reset) begin
      state       <= IDLE;
      chan        <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      left_hold   <= '0;
      right_hold  <= '0;
      have_left   <= 1'b0;
      pair_pend   <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      pair_pend   <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          if (lrck_edge) begin
            state <= SKIP;
            chan  <= lrck_lvl;
          end
        end
        SKIP, SHIFT: begin
          // An lrck edge always wins over a bclk rise in the same cycle.
          if (lrck_edge) begin
            framing_err <= 1'b1;
            if (chan) have_left <= 1'b0;
            chan    <= lrck_lvl;
            bit_cnt <= '0;
            state   <= SKIP;
          end else if (bclk_rise) begin
            if (state == SKIP) begin
              bit_cnt <= '0;
              state   <= SHIFT;
            end else begin
              shreg   <= word_next[DATA_W-2:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == LAST_BIT) begin
                state <= DRAIN;
                if (!chan) begin
                  left_hold <= word_next;
                  have_left <= 1'b1;
                end else begin
                  right_hold <= word_next;
                  pair_pend  <= have_left;
                  have_left  <= 1'b0;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (lrck_edge) begin
            chan  <= lrck_lvl;
            state <= SKIP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      sample_valid <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
    end else begin
      sample_valid <= pair_pend;
      if (pair_pend) begin
        left_data  <= left_hold;
        right_data <= right_hold;
      end
    end
  end

`ifdef I2S_RX_PEAK_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  // Magnitude that saturates the most negative code instead of wrapping to itself.
  function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] v);
    if (v == MOST_NEG) return MOST_POS;
    return v[DATA_W-1] ? -v : v;
  endfunction

  logic [DATA_W-1:0] abs_l;
  logic [DATA_W-1:0] abs_r;
  logic [DATA_W-1:0] peak_cand;

  assign abs_l     = sat_abs(left_data);
  assign abs_r     = sat_abs(right_data);
  assign peak_cand = (abs_l > abs_r) ? abs_l : abs_r;

  always_ff @(posedge clk50) begin
    if (reset || peak_clr) begin
      peak_level <= '0;
    end else if (sample_valid && (peak_cand > peak_level)) begin
      peak_level <= peak_cand;
    end
  end
`else
  logic peak_clr_unused;
  assign peak_clr_unused = peak_clr;
  assign peak_level      = '0;
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: drives I2S words at clk50/16 and checks against a word-level model.
`timescale 1ns/1ps
module tb_i2s_adc_rx;
  localparam int W    = 16;
  localparam int HALF = 8;
`ifdef I2S_RX_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk50 = 1'b0;
  logic reset = 1'b1;
  logic aud_bclk = 1'b0, aud_adclrck = 1'b0, aud_adcdat = 1'b0, peak_clr = 1'b0;
  logic [W-1:0] left_data, right_data, peak_level;
  logic sample_valid, framing_err;
  logic [1:0] dbg_state;

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  i2s_adc_rx #(.DATA_W(W)) dut (
    .clk50(clk50), .reset(reset), .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck),
    .aud_adcdat(aud_adcdat), .peak_clr(peak_clr), .left_data(left_data),
    .right_data(right_data), .sample_valid(sample_valid), .framing_err(framing_err),
    .peak_level(peak_level), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- word-level model ----------------
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0] m_left = '0, m_right = '0, m_peak = '0, m_left_word = '0;
  bit m_have_left = 0, m_prev_active = 0, m_prev_trunc = 0, m_prev_ch = 0;
  int fe_exp = 0, fe_seen = 0;
  int last_bit_cyc = 0, sv_cyc = 0;
  bit prev_rst = 0;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    int s;
    s = int'($signed(v));
    if (s == -(1 << (W-1))) return W'((1 << (W-1)) - 1);
    return W'((s < 0) ? -s : s);
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Called at each channel boundary the bench produces: a word is full when it carries
  // all W bits after its delay slot; a short word is reported at the following boundary.
  task automatic model_word(input logic ch, input bit complete, input logic [W-1:0] value);
    if (m_prev_active && m_prev_trunc) begin
      fe_exp++;
      if (m_prev_ch) m_have_left = 0;
    end
    m_prev_active = 1;
    m_prev_trunc  = !complete;
    m_prev_ch     = ch;
    if (complete) begin
      if (!ch) begin
        m_left_word = value;
        m_have_left = 1;
      end else begin
        if (m_have_left) exp_q.push_back({m_left_word, value});
        m_have_left = 0;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_have_left   = 0;
    m_prev_active = 0;
    m_prev_trunc  = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk50) begin
    if (prev_rst) begin
      check("rst_sample_valid", sample_valid, 0);
      check("rst_framing_err", framing_err, 0);
      check("rst_left_data", left_data, 0);
      check("rst_right_data", right_data, 0);
      check("rst_peak_level", peak_level, 0);
    end else begin
      if (sample_valid) begin
        sv_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_sample_valid", 1, 0);
        else {m_left, m_right} = exp_q.pop_front();
      end
      check("left_data", left_data, m_left);
      check("right_data", right_data, m_right);
      check("peak_level", peak_level, m_peak);
      if (framing_err) fe_seen++;
    end
    if (reset) begin
      m_left  = '0;
      m_right = '0;
      m_peak  = '0;
    end else if (PEAK_EN) begin
      if (peak_clr) m_peak = '0;
      else if (sample_valid) m_peak = max3(m_peak, mag(m_left), mag(m_right));
    end
    prev_rst = reset;
  end

  // ---------------- drivers ----------------
  // Entered and left at posedge+2. off is the slot carrying the MSB: 1 normally, 2 when the
  // lrck edge is placed on a bclk rise (that rise is ignored by the receiver).
  task automatic send_word(input logic [W-1:0] value, input int nslots, input bit coinc,
                           input bit track);
    int off;
    logic ch;
    off = coinc ? 2 : 1;
    ch  = ~aud_adclrck;
    if (track) model_word(ch, nslots >= off + W, value);
    for (int i = 0; i < nslots; i++) begin
      aud_bclk = 1'b0;
      if (i == 0 && !coinc) aud_adclrck = ch;
      if (i >= off && i < off + W) aud_adcdat = value[W-1-(i-off)];
      else aud_adcdat = 1'($urandom_range(0, 1));
      repeat (HALF) @(posedge clk50);
      #2;
      aud_bclk = 1'b1;
      if (i == 0 && coinc) aud_adclrck = ch;
      if (i == off + W - 1) last_bit_cyc = cyc;
      repeat (HALF) @(posedge clk50);
      #2;
    end
  endtask

  task automatic checkpoint(input string tag);
    repeat (20) @(posedge clk50);
    #2;
    check({tag, "_pairs_pending"}, exp_q.size(), 0);
    check({tag, "_framing_count"}, fe_seen, fe_exp);
  endtask

  task automatic pulse_peak_clr();
    peak_clr = 1'b1;
    @(posedge clk50);
    #2;
    peak_clr = 1'b0;
  endtask

  initial begin
    repeat (200000) @(posedge clk50);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int nslots;
    bit coinc;
    int fe_before;

    repeat (4) @(posedge clk50);
    @(negedge clk50);
    check("reset_left_data", left_data, 16'h0000);
    check("reset_sample_valid", sample_valid, 0);
    @(posedge clk50);
    #2;

    // Startup: reset released 20 slots into a right word. The zeroed synchronizers see the
    // high lrck as an edge, so the tail of that word is a truncated right word.
    fork
      send_word(W'($urandom), 32, 0, 0);
      begin
        repeat (20 * 2 * HALF) @(posedge clk50);
        #2;
        reset = 1'b0;
      end
    join
    m_prev_active = 1;
    m_prev_trunc  = 1;
    m_prev_ch     = 1;

    // Normal frame
    send_word(16'h1234, 32, 0, 1);
    send_word(16'hFEDC, 32, 0, 1);
    check("normal_latency", sv_cyc - last_bit_cyc, 4);
    check("normal_left_lit", left_data, 16'h1234);
    check("normal_right_lit", right_data, 16'hFEDC);
    check("startup_fe_lit", fe_seen, 1);
    checkpoint("normal");

    // Truncated left word after 10 bits
    fe_before = fe_seen;
    send_word(W'($urandom), 11, 0, 1);
    send_word(W'($urandom), 32, 0, 1);
    send_word(16'h0001, 32, 0, 1);
    send_word(16'h0002, 32, 0, 1);
    check("trunc_fe_once", fe_seen - fe_before, 1);
    check("trunc_left_lit", left_data, 16'h0001);
    check("trunc_right_lit", right_data, 16'h0002);
    checkpoint("trunc");

    // Coincident lrck edge and bclk rise
    send_word(16'hA5C3, 32, 1, 1);
    send_word(16'h5A3C, 32, 1, 1);
    check("coinc_left_lit", left_data, 16'hA5C3);
    check("coinc_right_lit", right_data, 16'h5A3C);
    checkpoint("coinc");

    // One-cycle reset during left bit 7
    fork
      send_word(W'($urandom), 32, 0, 1);
      begin
        repeat (8 * 2 * HALF + 2) @(posedge clk50);
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clk50);
        #2;
        reset = 1'b0;
        @(negedge clk50);
        check("midrst_left_lit", left_data, 16'h0000);
        check("midrst_right_lit", right_data, 16'h0000);
        check("midrst_peak_lit", peak_level, 16'h0000);
      end
    join
    send_word(W'($urandom), 32, 0, 1);
    send_word(16'h3C3C, 32, 0, 1);
    send_word(16'hC001, 32, 0, 1);
    check("midrst_resume_left", left_data, 16'h3C3C);
    check("midrst_resume_right", right_data, 16'hC001);
    checkpoint("midrst");

    // Peak meter
    pulse_peak_clr();
    send_word(16'h0100, 32, 0, 1);
    send_word(16'hFF00, 32, 0, 1);
    check("peak_first_lit", peak_level, PEAK_EN ? 16'h0100 : 16'h0000);
    send_word(16'h8000, 32, 0, 1);
    send_word(16'h0000, 32, 0, 1);
    check("peak_second_lit", peak_level, PEAK_EN ? 16'h7FFF : 16'h0000);
    pulse_peak_clr();
    @(negedge clk50);
    check("peak_cleared_lit", peak_level, 16'h0000);
    @(posedge clk50);
    #2;
    checkpoint("peak");

    // Randomized words: mostly full, some truncated, some with coincident edges
    for (int k = 0; k < 48; k++) begin
      coinc = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) nslots = $urandom_range(1, (coinc ? 2 : 1) + W - 1);
      else nslots = 32;
      send_word(W'($urandom), nslots, coinc, 1);
    end
    send_word(W'($urandom), 32, 0, 1);
    checkpoint("random");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
